// File: rtl/tx_pkg.sv
// Shared types and defaults for the order transmit scheduler.
package tx_pkg;

  typedef enum logic {
    BUY  = 1'b0,
    SELL = 1'b1
  } side_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } tx_state_t;

  localparam int DEF_MSG_WORDS = 9;
  localparam int DROP_W        = 16;

endpackage

// File: rtl/tx_msg_buffer.sv
// One side-message capture register with a word-select read mux.
// Read is combinational from the index; load is a one-cycle strobe with no backpressure.
module tx_msg_buffer #(
  parameter int REG_WIDTH = 32,
  parameter int MSG_WORDS = 9,
  parameter int IDX_W     = 4
) (
  input  logic                                i_clk,
  input  logic                                i_load,
  input  logic [MSG_WORDS-1:0][REG_WIDTH-1:0] i_msg,
  input  logic [IDX_W-1:0]                    i_sel,
  output logic [REG_WIDTH-1:0]                o_word
);

  logic [MSG_WORDS-1:0][REG_WIDTH-1:0] buf_q;

  // Left unreset: contents are only ever read after a fresh capture.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      buf_q <= i_msg;
    end
  end

  always_comb begin
    o_word = '0;
    if (int'(i_sel) < MSG_WORDS) begin
      o_word = buf_q[i_sel];
    end
  end

endmodule

// File: rtl/order_tx_scheduler.sv
// Serialises a captured buy/sell message pair as two back-to-back streams; first word 1 cycle after i_valid.
// Holds data while i_tready is low; i_valid while busy is dropped and counted. Option: TX_SIDE_ROUND_ROBIN_EN.
module order_tx_scheduler
  import tx_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int MSG_WORDS = DEF_MSG_WORDS
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_valid,
  input  logic [MSG_WORDS-1:0][REG_WIDTH-1:0] i_msg_b,
  input  logic [MSG_WORDS-1:0][REG_WIDTH-1:0] i_msg_s,
  input  logic                                i_tready,
  output logic [REG_WIDTH-1:0]                o_tdata,
  output logic                                o_tvalid,
  output logic                                o_tlast,
  output logic                                o_tside,
  output logic                                o_busy,
  output logic [DROP_W-1:0]                   o_drop_count
);

  localparam int                IDX_W    = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MSG_WORDS - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  tx_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                 busy, capture, hs, last_word;
  side_t                first_side, cur_side;
  logic [REG_WIDTH-1:0] word_b, word_s;

  assign busy      = (state_q != IDLE);
  assign capture   = (state_q == IDLE) && i_valid;
  assign hs        = busy && i_tready;
  assign last_word = (idx_q == LAST_IDX);

`ifdef TX_SIDE_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  assign rr_d = capture ? ~rr_q : rr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // The flag toggles at capture, so the in-flight quote leads with its complement.
  assign first_side = rr_q ? BUY : SELL;
`else
  assign first_side = BUY;
`endif

  always_comb begin
    cur_side = first_side;
    if (state_q == SEND_SECOND) begin
      cur_side = (first_side == BUY) ? SELL : BUY;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = SEND_FIRST;
          idx_d   = '0;
        end
      end
      SEND_FIRST: begin
        if (hs) begin
          if (last_word) begin
            state_d = SEND_SECOND;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      SEND_SECOND: begin
        if (hs) begin
          if (last_word) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_valid && busy && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  tx_msg_buffer #(
    .REG_WIDTH (REG_WIDTH),
    .MSG_WORDS (MSG_WORDS),
    .IDX_W     (IDX_W)
  ) u_buf_b (
    .i_clk  (i_clk),
    .i_load (capture),
    .i_msg  (i_msg_b),
    .i_sel  (idx_q),
    .o_word (word_b)
  );

  tx_msg_buffer #(
    .REG_WIDTH (REG_WIDTH),
    .MSG_WORDS (MSG_WORDS),
    .IDX_W     (IDX_W)
  ) u_buf_s (
    .i_clk  (i_clk),
    .i_load (capture),
    .i_msg  (i_msg_s),
    .i_sel  (idx_q),
    .o_word (word_s)
  );

  // Outputs derive from reset flops only, so reset clears them without waiting for a clock.
  assign o_tvalid     = busy;
  assign o_busy       = busy;
  assign o_tlast      = busy && last_word;
  assign o_tside      = busy && (cur_side == SELL);
  assign o_tdata      = busy ? ((cur_side == SELL) ? word_s : word_b) : '0;
  assign o_drop_count = drop_cnt_q;

endmodule
